// File: rtl/data_send.sv
// -----------------------------------------------------------------------------
// data_send
//   AXI-Stream burst generator. A rising edge on start_send launches one burst
//   of eff_len beats (eff_len = len, or MAX_LEN when len is 0). Each beat
//   carries {burst_id, beat_idx}. The final beat has tlast set and uses the
//   captured last_keep; every other beat uses DEFAULT_KEEP. A one-cycle done
//   pulse follows acceptance of the final beat. burst_id advances once per
//   completed burst.
//
// Ports
//   aclk           in   clock, rising edge
//   aresetn        in   synchronous active-low reset
//   start_send     in   level request; a burst starts on its rising edge
//   len[7:0]       in   burst length in beats (0 = MAX_LEN), captured at start
//   last_keep[3:0] in   tkeep for the tlast beat, captured at start
//   m_axis_*       AXI-Stream master (tvalid/tready/tdata/tkeep/tlast)
//   busy           out  high from start acceptance until last beat accepted
//   done           out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module data_send #(
  parameter logic [3:0] DEFAULT_KEEP = 4'hF,
  parameter int         MAX_LEN      = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start_send,
  input  logic [7:0]  len,
  input  logic [3:0]  last_keep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q,     state_d;
  logic        start_dly_q;
  // Set once start_send has been seen low after reset, so a request held
  // high through reset release cannot launch a burst.
  logic        armed_q;
  logic [15:0] beat_idx_q,  beat_idx_d;
  logic [15:0] burst_id_q,  burst_id_d;
  logic [15:0] last_idx_q,  last_idx_d;
  logic [3:0]  last_keep_q, last_keep_d;
  logic        tvalid_q,    tvalid_d;
  logic [31:0] tdata_q,     tdata_d;
  logic [3:0]  tkeep_q,     tkeep_d;
  logic        tlast_q,     tlast_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;

  logic        rise;
  logic        xfer;
  logic [15:0] start_last_idx;
  logic [15:0] next_idx;
  logic        next_is_last;

  assign rise = start_send & ~start_dly_q & armed_q;
  assign xfer = tvalid_q & m_axis_tready;

  // Index of the final beat for a burst requested right now.
  assign start_last_idx = (len == 8'd0) ? 16'(MAX_LEN - 1)
                                        : ({8'd0, len} - 16'd1);
  assign next_idx       = beat_idx_q + 16'd1;
  assign next_is_last   = (next_idx == last_idx_q);

  // State and output registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      start_dly_q <= 1'b0;
      armed_q     <= 1'b0;
      beat_idx_q  <= 16'd0;
      burst_id_q  <= 16'd0;
      last_idx_q  <= 16'd0;
      last_keep_q <= 4'd0;
      tvalid_q    <= 1'b0;
      tdata_q     <= 32'd0;
      tkeep_q     <= 4'd0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_send;
      armed_q     <= armed_q | ~start_send;
      beat_idx_q  <= beat_idx_d;
      burst_id_q  <= burst_id_d;
      last_idx_q  <= last_idx_d;
      last_keep_q <= last_keep_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = rise ? ST_SEND : ST_IDLE;
      ST_SEND: state_d = (xfer && tlast_q) ? ST_DONE : ST_SEND;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    beat_idx_d  = beat_idx_q;
    burst_id_d  = burst_id_q;
    last_idx_d  = last_idx_q;
    last_keep_d = last_keep_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
        if (rise) begin
          last_idx_d  = start_last_idx;
          last_keep_d = last_keep;
          beat_idx_d  = 16'd0;
          tdata_d     = {burst_id_q, 16'd0};
          tvalid_d    = 1'b1;
          busy_d      = 1'b1;
          tlast_d     = (start_last_idx == 16'd0);
          tkeep_d     = (start_last_idx == 16'd0) ? last_keep : DEFAULT_KEEP;
        end
      end
      ST_SEND: begin
        // Without a transfer everything holds, keeping the beat stable.
        if (xfer) begin
          if (tlast_q) begin
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            burst_id_d = burst_id_q + 16'd1;
          end else begin
            beat_idx_d = next_idx;
            tdata_d    = {burst_id_q, next_idx};
            tlast_d    = next_is_last;
            tkeep_d    = next_is_last ? last_keep_q : DEFAULT_KEEP;
          end
        end
      end
      ST_DONE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
        tdata_d  = 32'd0;
        tkeep_d  = 4'd0;
      end
    endcase
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
